// File: rtl/micro_fsm.sv
// micro_fsm: GPIO-commanded controller for the 2-D convolution prototype.
// Latency: a load write commits 1 cycle after the strobe edge is registered;
//    a RUN pass takes img_len+2 cycles from the SOP edge to the DONE state;
//    a readout strobe updates the data field 2 cycles after it is sampled.
// Backpressure: none. The host must hold each command word for at least 2 clocks.
//
// Ports:
//    CLK100MHZ          single rising-edge clock
//    gpio_o_data_tri_o  host command word; bit 0 is a synchronous active-high reset
//    gpio_i_data_tri_i  status/result word: [31] done, [30] in LOAD,
//                       [CONV_LEN-1:0] result at the read pointer while in DONE
//    o_led              one-hot state: [0] IDLE, [1] LOAD, [2] RUN, [3] DONE
//
// Build option: define MICRO_FMS_SAT_EN to clamp every stored result to 2^BIT_LEN-1.
module micro_fsm #(
   parameter int BIT_LEN    = 8,
   parameter int CONV_LEN   = 20,
   parameter int NB_ADDRESS = 10,
   parameter int NB_IMAGE   = 10,
   parameter int GPIO_D     = 32
) (
   input  logic              CLK100MHZ,
   input  logic [GPIO_D-1:0] gpio_o_data_tri_o,
   output logic [GPIO_D-1:0] gpio_i_data_tri_i,
   output logic [3:0]        o_led
);

   localparam int DEPTH = 1 << NB_ADDRESS;
   // Length/count width needs one bit more than an address to hold DEPTH itself.
   localparam int LW    = NB_ADDRESS + 1;

   localparam logic [1:0] MEM0 = 2'd1;
   localparam logic [1:0] MEM1 = 2'd2;
   localparam logic [1:0] MEM2 = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   // Command word fields
   logic                rst;
   logic                run_en;
   logic                len_latch;
   logic                sop;
   logic                strobe;
   logic [1:0]          sel;
   logic                load_mode;
   logic [BIT_LEN-1:0]  data;
   logic [NB_IMAGE-1:0] len_field;
   logic                unused_bits;

   assign rst         = gpio_o_data_tri_o[0];
   assign run_en      = gpio_o_data_tri_o[1];
   assign len_latch   = gpio_o_data_tri_o[2];
   assign sop         = gpio_o_data_tri_o[3];
   assign strobe      = gpio_o_data_tri_o[4];
   assign sel         = gpio_o_data_tri_o[6:5];
   assign load_mode   = gpio_o_data_tri_o[7];
   assign data        = gpio_o_data_tri_o[15:8];
   assign len_field   = gpio_o_data_tri_o[NB_IMAGE+7:8];
   assign unused_bits = &{1'b0, gpio_o_data_tri_o[GPIO_D-1:NB_IMAGE+8]};

   // State and control registers
   state_t                state;
   logic                  sop_q, strobe_q;
   logic                  sop_rise_q, strobe_rise_q;
   logic [1:0]            sel_q;
   logic [LW-1:0]         img_len;
   logic [LW-1:0]         proc_cnt;
   logic [NB_ADDRESS-1:0] wr_ptr;
   logic [NB_ADDRESS-1:0] rd_ptr;
   logic                  done;
   logic                  iss_vld;
   logic [NB_ADDRESS-1:0] iss_addr;

   // Memories and their read registers
   logic [BIT_LEN-1:0]  mem0 [DEPTH];
   logic [BIT_LEN-1:0]  mem1 [DEPTH];
   logic [BIT_LEN-1:0]  mem2 [DEPTH];
   logic [CONV_LEN-1:0] res_mem [DEPTH];
   logic [BIT_LEN-1:0]  m0_rd, m1_rd, m2_rd;
   logic [CONV_LEN-1:0] res_rd;

   // Length latch with clamp to the RAM depth
   logic [LW-1:0] len_clamped;
   always_comb begin
      len_clamped = LW'(len_field);
      if (int'(len_field) > DEPTH)
         len_clamped = LW'(DEPTH);
   end

   // A select change restarts the write pointer; a strobe in that same cycle
   // lands at word 0 of the newly selected memory.
   logic [NB_ADDRESS-1:0] wr_addr;
   logic [NB_ADDRESS-1:0] wr_ptr_nxt;
   logic                  load_we;
   assign wr_addr    = (sel != sel_q) ? '0 : wr_ptr;
   assign wr_ptr_nxt = wr_addr + NB_ADDRESS'(strobe_rise_q);
   assign load_we    = !rst && (state == S_LOAD) && strobe_rise_q;

   logic rd_wrap;
   assign rd_wrap = (LW'(rd_ptr) + LW'(1)) >= img_len;

   always_ff @(posedge CLK100MHZ) begin
      // Edge history follows the input even in reset, so a bit held high
      // across reset release does not look like a fresh edge.
      sop_q    <= sop;
      strobe_q <= strobe;
      sel_q    <= sel;
      iss_vld  <= 1'b0;
      if (rst) begin
         state         <= S_IDLE;
         sop_rise_q    <= 1'b0;
         strobe_rise_q <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         proc_cnt      <= '0;
         done          <= 1'b0;
         iss_addr      <= '0;
         img_len       <= len_latch ? len_clamped : '0;
      end else begin
         sop_rise_q    <= sop & ~sop_q;
         strobe_rise_q <= strobe & ~strobe_q;
         case (state)
            S_IDLE: begin
               if (load_mode) begin
                  state  <= S_LOAD;
                  wr_ptr <= '0;
               end else if (run_en && sop_rise_q) begin
                  state    <= S_RUN;
                  proc_cnt <= '0;
               end
            end
            S_LOAD: begin
               wr_ptr <= wr_ptr_nxt;
               if (!load_mode)
                  state <= S_IDLE;
            end
            S_RUN: begin
               // One read issued per cycle; the final result is written on
               // the same edge that moves to DONE.
               if (proc_cnt == img_len) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  iss_vld  <= 1'b1;
                  iss_addr <= proc_cnt[NB_ADDRESS-1:0];
                  proc_cnt <= proc_cnt + LW'(1);
               end
            end
            S_DONE: begin
               if (run_en && sop_rise_q) begin
                  state    <= S_RUN;
                  done     <= 1'b0;
                  rd_ptr   <= '0;
                  proc_cnt <= '0;
               end else if (load_mode) begin
                  state  <= S_LOAD;
                  wr_ptr <= '0;
               end else if (strobe_rise_q) begin
                  rd_ptr <= rd_wrap ? '0 : rd_ptr + NB_ADDRESS'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Column memories: host writes, synchronous reads addressed by the run counter
   always_ff @(posedge CLK100MHZ) begin
      if (load_we && sel == MEM0) mem0[wr_addr] <= data;
      if (load_we && sel == MEM1) mem1[wr_addr] <= data;
      if (load_we && sel == MEM2) mem2[wr_addr] <= data;
      m0_rd <= mem0[proc_cnt[NB_ADDRESS-1:0]];
      m1_rd <= mem1[proc_cnt[NB_ADDRESS-1:0]];
      m2_rd <= mem2[proc_cnt[NB_ADDRESS-1:0]];
   end

   // [1,2,1] column filter on the registered read data
   logic [BIT_LEN+1:0]  sum_full;
   logic [CONV_LEN-1:0] res_val;
   assign sum_full = {2'b00, m0_rd} + {1'b0, m1_rd, 1'b0} + {2'b00, m2_rd};

`ifdef MICRO_FMS_SAT_EN
   localparam logic [BIT_LEN+1:0] SAT_MAX = {2'b00, {BIT_LEN{1'b1}}};
   assign res_val = (sum_full > SAT_MAX) ? CONV_LEN'(SAT_MAX) : CONV_LEN'(sum_full);
`else
   assign res_val = CONV_LEN'(sum_full);
`endif

   // Result memory: pipeline writes, synchronous read at the host read pointer
   always_ff @(posedge CLK100MHZ) begin
      if (iss_vld && !rst)
         res_mem[iss_addr] <= res_val;
      res_rd <= res_mem[rd_ptr];
   end

   // Outputs are decoded from registers only
   always_comb begin
      gpio_i_data_tri_i = '0;
      if (state == S_DONE)
         gpio_i_data_tri_i[CONV_LEN-1:0] = res_rd;
      gpio_i_data_tri_i[GPIO_D-1] = done;
      gpio_i_data_tri_i[GPIO_D-2] = (state == S_LOAD);
   end

   always_comb begin
      o_led = 4'b0000;
      case (state)
         S_IDLE:  o_led = 4'b0001;
         S_LOAD:  o_led = 4'b0010;
         S_RUN:   o_led = 4'b0100;
         S_DONE:  o_led = 4'b1000;
         default: o_led = 4'b0000;
      endcase
   end

endmodule

// File: tb/tb_micro_fsm.sv
// tb_micro_fsm: directed-vector bench for micro_fsm.
// Drives GPIO command words 2 ns after the rising edge and samples there too.
// Expected values are hand-computed from the [1,2,1] filter on the loaded data.
module tb_micro_fsm;

   logic        clk;
   logic [31:0] g;
   logic [31:0] gi;
   logic [3:0]  led;

   int n_chk  = 0;
   int n_fail = 0;

   micro_fsm dut (
      .CLK100MHZ         (clk),
      .gpio_o_data_tri_o (g),
      .gpio_i_data_tri_i (gi),
      .o_led             (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MICRO_FMS_SAT_EN
   localparam logic [31:0] R0 = 32'hFF;
   localparam logic [31:0] R1 = 32'hFF;
   localparam logic [31:0] R2 = 32'hFF;
`else
   // 0x7f+2*0x7f+0x7f = 0x1FC, 0x7e*4 = 0x1F8
   localparam logic [31:0] R0 = 32'h1FC;
   localparam logic [31:0] R1 = 32'h1FC;
   localparam logic [31:0] R2 = 32'h1F8;
`endif

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Apply a command word and hold it for n rising edges.
   task automatic drive(input logic [31:0] w, input int n);
      g = w;
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Three bytes into the memory selected by base (g[7]=1, g[6:5]=select).
   task automatic load_mem(input logic [31:0] base, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2);
      logic [7:0] dv [3];
      dv[0] = d0; dv[1] = d1; dv[2] = d2;
      for (int i = 0; i < 3; i++) begin
         drive(base | (32'(dv[i]) << 8), 3);
         drive(base | 32'h10 | (32'(dv[i]) << 8), 3);
      end
   endtask

   initial begin
      logic [31:0] rd_exp [3];
      int n;
      g = 32'h0;
      #2;

      // Reset and length latch
      drive(32'h5, 3);
      chk("rst_led", 32'(led), 32'h1);
      chk("rst_gpio", gi, 32'h0);
      drive(32'h1B705, 3);
      drive(32'h0, 3);
      chk("len439_led", 32'(led), 32'h1);
      chk("len439_gpio", gi, 32'h0);
      chk("len439", 32'(dut.img_len), 32'd439);

      // Length 3, then load three memories
      drive(32'h305, 3);
      drive(32'h0, 3);
      chk("len3", 32'(dut.img_len), 32'd3);
      load_mem(32'hA0, 8'h7f, 8'h7f, 8'h7e);
      chk("load_led", 32'(led), 32'h2);
      chk("load_gpio", gi, 32'h4000_0000);
      load_mem(32'hC0, 8'h7f, 8'h7f, 8'h7e);
      load_mem(32'hE0, 8'h7f, 8'h7f, 8'h7e);
      chk("load_gpio2", gi, 32'h4000_0000);
      drive(32'h0, 3);
      chk("idle_led", 32'(led), 32'h1);
      for (int i = 0; i < 3; i++) begin
         logic [7:0] e;
         e = (i == 2) ? 8'h7e : 8'h7f;
         chk($sformatf("mem0[%0d]", i), 32'(dut.mem0[i]), 32'(e));
         chk($sformatf("mem1[%0d]", i), 32'(dut.mem1[i]), 32'(e));
         chk($sformatf("mem2[%0d]", i), 32'(dut.mem2[i]), 32'(e));
      end

      // RUN: SOP edge to DONE LED is img_len+2 = 5 cycles
      g = 32'h0A;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #2;
         n++;
         if (n == 2) g = 32'h02;
         if (led == 4'b1000) break;
      end
      chk("run_latency", 32'(n - 1), 32'd5);
      drive(32'h02, 3);
      chk("done_gpio", gi, 32'h8000_0000 | R0);

      // Readout strobes, wrapping after img_len-1
      rd_exp[0] = R1; rd_exp[1] = R2; rd_exp[2] = R0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h10, 3);
         drive(32'h0, 3);
         chk($sformatf("read%0d", i), gi, 32'h8000_0000 | rd_exp[i]);
      end

      // DONE -> LOAD keeps done; back to IDLE keeps it too
      drive(32'h80, 3);
      chk("done_load_led", 32'(led), 32'h2);
      chk("done_load_gpio", gi, 32'hC000_0000);
      drive(32'h0, 3);
      chk("idle_done_led", 32'(led), 32'h1);
      chk("idle_done_gpio", gi, 32'h8000_0000);

      // Reset in the middle of a RUN pass
      g = 32'h0A;
      repeat (3) @(posedge clk);
      #2;
      chk("midrun_led", 32'(led), 32'h4);
      g = 32'h5;
      @(posedge clk); #2;
      chk("abort_led", 32'(led), 32'h1);
      chk("abort_gpio", gi, 32'h0);
      chk("abort_len", 32'(dut.img_len), 32'd0);
      drive(32'h0A, 4);
      chk("len0_led", 32'(led), 32'h8);
      chk("len0_done", gi >> 30, 32'h2);

      // Strobe held high through reset release must not write or advance
      drive(32'h55B1, 3);
      drive(32'h55B0, 4);
      chk("hold_led", 32'(led), 32'h2);
      chk("hold_gpio", gi, 32'h4000_0000);
      drive(32'h11A0, 3);
      drive(32'h11B0, 3);
      drive(32'h11A0, 3);
      chk("hold_mem0_0", 32'(dut.mem0[0]), 32'h11);
      chk("hold_mem0_1", 32'(dut.mem0[1]), 32'h7f);
      chk("hold_wr_ptr", 32'(dut.wr_ptr), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/micro_fsm.md
# micro_fsm

GPIO-driven top-level controller for the 2-D convolution prototype. A host writes one 32-bit GPIO word to command it: reset, latch the image length, load three column memories, start processing, and step through results. The block holds the command FSM, three input column RAMs, a fixed [1,2,1] column filter and a result RAM. Results and status are returned on the input-direction GPIO word; state is shown on four LEDs.

## Interface
- BIT_LEN, 8: pixel width.
- CONV_LEN, 20: result width stored and returned.
- NB_ADDRESS, 10: address width of every RAM (depth 2^NB_ADDRESS).
- NB_IMAGE, 10: image-length register width.
- GPIO_D, 32: GPIO word width.
- Memory-select codes, fixed: MEM0=1, MEM1=2, MEM2=3.

Ports:
- CLK100MHZ  in  1  single clock; every register is on the rising edge.
- gpio_o_data_tri_o  in  GPIO_D  host command word. Bit 0 is the reset: synchronous, active-high. There is no separate reset pin.
- gpio_i_data_tri_i  out  GPIO_D  result and status word.
- o_led  out  4  one-hot state: [0] IDLE, [1] LOAD, [2] RUN, [3] DONE.

## Operation
Command-word fields (g = gpio_o_data_tri_o):
- g[0] is the reset. g[1] is run enable. g[2] latches the image length, and only acts while g[0]=1. g[3] is start of processing (SOP). g[4] is the data strobe. g[6:5] is the memory select. g[7] is load mode. g[15:8] is the data byte. g[NB_IMAGE+7:8] is the length field.
- Edge detection: g[3] and g[4] are registered every cycle. rise = current & ~previous. During reset the previous-value registers load the current input, so a bit held high through reset produces no edge.

Reset (g[0]=1):
- State goes to IDLE. The write and read pointers, the process counter and done are cleared. gpio_i goes to 0.
- If g[2]=1, img_len <= g[17:8]; otherwise img_len <= 0.
- img_len values above 2^NB_ADDRESS are clamped to 2^NB_ADDRESS.

States:
- IDLE: g[7]=1 goes to LOAD. g[1]=1 with rise(g[3]) goes to RUN.
- LOAD:
  - wr_ptr clears on entry and whenever g[6:5] changes.
  - On rise(g[4]), memory[g[6:5]][wr_ptr] <= g[15:8] and wr_ptr increments, wrapping at 2^NB_ADDRESS. Select 0 ignores writes.
  - g[7]=0 returns to IDLE.
- RUN:
  - One address a = 0..img_len-1 per cycle. res[a] = mem0[a] + 2*mem1[a] + mem2[a], unsigned, zero-extended to CONV_LEN.
  - All other command bits are ignored except reset.
  - After the last address, goes to DONE and sets done=1.
  - img_len=0 goes straight to DONE, with no writes.
- DONE:
  - rd_ptr starts at 0 and increments on rise(g[4]) when g[7]=0, wrapping to 0 after img_len-1.
  - g[1]=1 with rise(g[3]) re-enters RUN: done and rd_ptr clear, result RAM is overwritten.
  - g[7]=1 goes to LOAD; done stays set.

Output word:
- gpio_i[CONV_LEN-1:0] = res[rd_ptr] in DONE, otherwise 0.
- gpio_i[31] = done. gpio_i[30] = 1 in LOAD. All other bits are 0.

## Timing
- RAMs are synchronous-read with 1-cycle latency.
- RUN takes img_len+2 cycles from the SOP edge until the DONE LED: 1 cycle to enter, plus the pipeline.
- A readout strobe edge updates gpio_i data 2 cycles after the g[4] rising sample (edge register, then RAM read).
- A load write commits 1 cycle after the edge is detected.
- The host must hold each command word for at least 2 clocks.
- When reset and any other command fall in the same cycle, reset wins.

## Configuration
- MICRO_FMS_SAT_EN:
  - Defined: each result is clamped to 2^BIT_LEN-1 (255) before storage; upper result bits read 0.
  - Undefined: the full-width sum (max 1020) is stored.

## Test plan
- 0x5, then 0x1b705, then 0x0 -> LEDs = IDLE (0001), img_len = 439 (0x1B7), gpio_i = 0.
- Write 0x7f,0x7f,0x7e using g[7]=1 with select MEM0 (0xA0 base, 0xB0 strobes), then MEM1 (0xC0), then MEM2 (0xE0); img_len=3 -> words 0..2 of each memory hold 0x7f,0x7f,0x7e, and gpio_i[30]=1 while in LOAD.
- Then 0x0A followed by 0x02 -> RUN LED for about 5 cycles, then DONE with gpio_i[31]=1 and gpio_i[19:0]=0x1FC.
- Toggle 0x10/0x0 three times -> data reads 0x1FC, 0x1F8, then 0x1FC (wrapped). With MICRO_FMS_SAT_EN defined, every value reads 0xFF.
- 0x5 asserted mid-RUN -> IDLE on the next clock, done=0, gpio_i=0, img_len=0; a following 0x0A goes straight to DONE.
- Hold g[4]=1 through a reset release -> no spurious write or pointer advance.
